// File: rtl/module_serializer.sv
// module_serializer: framed LSB-first serializer (start, data, optional parity, stop), BIT_CYCLES clocks per bit.
// Define SERIALIZER_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module module_serializer #(
    parameter int WIDTH      = 4,
    parameter int BIT_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] d,
    output logic             load_ready,
    output logic             sout,
    output logic             busy,
    output logic             done
);
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [7:0] RELOAD = 8'(BIT_CYCLES - 1);
    localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef SERIALIZER_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sr;
    logic [BW-1:0]    r_bit;
    logic [7:0]       r_cnt;
    logic             r_sout;
    logic             r_busy;
    logic             r_done;
`ifdef SERIALIZER_PARITY_EN
    logic             r_par;
`endif

    logic             w_tick;
    logic [WIDTH-1:0] w_shift;

    assign w_tick     = r_cnt == 8'd0;
    assign w_shift    = r_sr >> 1;
    assign load_ready = r_state == IDLE;
    assign sout       = r_sout;
    assign busy       = r_busy;
    assign done       = r_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_bit   <= '0;
            r_cnt   <= '0;
            r_sout  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            r_cnt  <= w_tick ? r_cnt : r_cnt - 8'd1;
            case (r_state)
                IDLE: if (load_valid) begin
                    r_sr    <= d;
                    r_bit   <= '0;
                    r_cnt   <= RELOAD;
                    r_sout  <= 1'b0;
                    r_busy  <= 1'b1;
                    r_state <= START;
`ifdef SERIALIZER_PARITY_EN
                    r_par   <= ^d;
`endif
                end
                START: if (w_tick) begin
                    r_cnt   <= RELOAD;
                    r_sout  <= r_sr[0];
                    r_state <= DATA;
                end
                DATA: if (w_tick) begin
                    r_cnt <= RELOAD;
                    if (r_bit == LAST) begin
`ifdef SERIALIZER_PARITY_EN
                        r_sout  <= r_par;
                        r_state <= PARITY;
`else
                        r_sout  <= 1'b1;
                        r_state <= STOP;
`endif
                    end else begin
                        r_bit  <= r_bit + BW'(1);
                        r_sr   <= w_shift;
                        r_sout <= w_shift[0];
                    end
                end
`ifdef SERIALIZER_PARITY_EN
                PARITY: if (w_tick) begin
                    r_cnt   <= RELOAD;
                    r_sout  <= 1'b1;
                    r_state <= STOP;
                end
`endif
                STOP: if (w_tick) begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_module_serializer.sv
// tb_module_serializer: two serializer instances (4-bit/4 cycles and 8-bit/1 cycle) checked cycle by cycle
// against a frame-bit reference model, plus directed frame scenarios.
module tb_module_serializer;
`ifdef SERIALIZER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int W[2]  = '{4, 8};
    localparam int BC[2] = '{4, 1};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_lv = 1'b0, b_lv = 1'b0;
    logic [3:0] a_d = '0;
    logic [7:0] b_d = '0;
    logic       a_ready, a_sout, a_busy, a_done;
    logic       b_ready, b_sout, b_busy, b_done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    module_serializer #(.WIDTH(4), .BIT_CYCLES(4)) u_a (
        .clk(clk), .reset(rst), .load_valid(a_lv), .d(a_d),
        .load_ready(a_ready), .sout(a_sout), .busy(a_busy), .done(a_done)
    );

    module_serializer #(.WIDTH(8), .BIT_CYCLES(1)) u_b (
        .clk(clk), .reset(rst), .load_valid(b_lv), .d(b_d),
        .load_ready(b_ready), .sout(b_sout), .busy(b_busy), .done(b_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a frame is the list {start 0, data LSB first, [parity], stop 1}, each bit lasting BC cycles.
    function automatic logic [31:0] mk_frame(input int w, input logic [15:0] dv);
        logic [31:0] f = '1;
        logic p = 1'b0;
        f[0] = 1'b0;
        for (int i = 0; i < w; i++) begin
            f[i+1] = dv[i];
            p ^= dv[i];
        end
        if (PAR == 1) f[w+1] = p;
        return f;
    endfunction

    int          m_pos[2]   = '{-1, -1};
    logic [31:0] m_frame[2] = '{'1, '1};
    logic        m_done[2]  = '{1'b0, 1'b0};
    bit          live = 1'b0;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_pos[k]  = -1;
                m_done[k] = 1'b0;
            end else if (m_pos[k] < 0) begin
                m_done[k] = 1'b0;
                if (k == 0 ? a_lv : b_lv) begin
                    m_frame[k] = mk_frame(W[k], k == 0 ? 16'(a_d) : 16'(b_d));
                    m_pos[k]   = 0;
                end
            end else begin
                m_pos[k]++;
                if (m_pos[k] == (2 + W[k] + PAR) * BC[k]) begin
                    m_pos[k]  = -1;
                    m_done[k] = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) if (live) begin
        check("a_sout",  32'(a_sout),  32'(m_pos[0] < 0 ? 1'b1 : m_frame[0][m_pos[0] / BC[0]]));
        check("a_busy",  32'(a_busy),  32'(m_pos[0] >= 0));
        check("a_ready", 32'(a_ready), 32'(m_pos[0] < 0));
        check("a_done",  32'(a_done),  32'(m_done[0]));
        check("b_sout",  32'(b_sout),  32'(m_pos[1] < 0 ? 1'b1 : m_frame[1][m_pos[1] / BC[1]]));
        check("b_busy",  32'(b_busy),  32'(m_pos[1] >= 0));
        check("b_ready", 32'(b_ready), 32'(m_pos[1] < 0));
        check("b_done",  32'(b_done),  32'(m_done[1]));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int n;
        int dones;
        logic [10:0] got_bits;
        logic [10:0] exp_bits;
        cyc(2);
        rst  = 1'b0;
        live = 1'b1;
        cyc(1);
        check("rst_sout",  32'(a_sout),  32'd1);
        check("rst_busy",  32'(a_busy),  32'd0);
        check("rst_ready", 32'(a_ready), 32'd1);
        // 4'h5 frame: busy for the whole frame, done right after
        a_lv = 1'b1; a_d = 4'h5;
        cyc(1);
        a_lv = 1'b0;
        n = 0;
        while (a_busy && n < 100) begin n++; cyc(1); end
        check("len_5", 32'(n), 32'((6 + PAR) * 4));
        check("done_5", 32'(a_done), 32'd1);
        cyc(1);
        check("done_5_once", 32'(a_done), 32'd0);
        // 4'hA with load_valid held and d changed mid-frame; 4'hF follows back-to-back
        a_lv = 1'b1; a_d = 4'hA;
        cyc(1);
        a_d = 4'hF;
        n = 0;
        while (!a_done && n < 100) begin n++; cyc(1); end
        check("done_a_seen", 32'(a_done), 32'd1);
        cyc(1);
        a_lv = 1'b0;
        check("b2b_busy",  32'(a_busy), 32'd1);
        check("b2b_start", 32'(a_sout), 32'd0);
        n = 0;
        while (a_busy && n < 100) begin n++; cyc(1); end
        check("len_f", 32'(n), 32'((6 + PAR) * 4));
        // reset 10 cycles into a 4'h3 frame aborts it with no done
        a_lv = 1'b1; a_d = 4'h3;
        cyc(1);
        a_lv = 1'b0;
        cyc(10);
        rst = 1'b1; a_lv = 1'b1;
        cyc(1);
        rst = 1'b0; a_lv = 1'b0;
        check("abort_sout",  32'(a_sout),  32'd1);
        check("abort_busy",  32'(a_busy),  32'd0);
        check("abort_ready", 32'(a_ready), 32'd1);
        dones = 0;
        for (int i = 0; i < 30; i++) begin dones += int'(a_done); cyc(1); end
        check("abort_no_done", 32'(dones), 32'd0);
        // 8'hC3 at one cycle per bit
        b_lv = 1'b1; b_d = 8'hC3;
        cyc(1);
        b_lv = 1'b0;
        got_bits = '1;
        for (int i = 0; i < 10 + PAR; i++) begin got_bits[i] = b_sout; cyc(1); end
        exp_bits = (PAR == 1) ? 11'b10_1100_0011_0 : 11'b11_1100_0011_0;
        check("c3_bits", 32'(got_bits), 32'(exp_bits));
        check("c3_done", 32'(b_done), 32'd1);
        // random traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            rst  = ($urandom % 101) == 0;
            a_lv = ($urandom % 3) == 0;
            b_lv = ($urandom % 3) == 0;
            a_d  = 4'($urandom);
            b_d  = 8'($urandom);
            cyc(1);
        end
        rst = 1'b0; a_lv = 1'b0; b_lv = 1'b0;
        cyc(40);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/module_serializer.md
MODULE_SERIALIZER -- requirements
Module: module_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data word width in bits (legal 1..16).
REQ-002 SHALL have parameter BIT_CYCLES, default 4, clock cycles per serial bit (legal 1..255).
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port load_valid  input  1  producer presents a word on d.
REQ-006 SHALL have port d  input  WIDTH  parallel word to transmit.
REQ-007 SHALL have port load_ready  output  1  serializer can accept a word this cycle.
REQ-008 SHALL have port sout  output  1  serial line, idle high.
REQ-009 SHALL have port busy  output  1  frame in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse at frame end.

Function
REQ-011 SHALL implement FSM states IDLE, START, DATA, PARITY (only with macro), STOP.
REQ-012 SHALL drive load_ready = 1 only in IDLE, combinationally from state.
REQ-013 SHALL accept a word when load_valid && load_ready at a rising edge: capture d into an internal shift register, enter START next cycle.
REQ-014 SHALL ignore load_valid and d while busy; captured word unaffected by later d changes.
REQ-015 SHALL drive sout: IDLE 1, START 0, DATA current LSB of shift register, PARITY parity bit, STOP 1; sout registered, no glitches.
REQ-016 SHALL hold each bit for exactly BIT_CYCLES cycles via a down-counter reloaded to BIT_CYCLES-1 on every state/bit change.
REQ-017 SHALL send data LSB first, shifting right once per bit; bit counter counts WIDTH bits, DATA exits after bit WIDTH-1.
REQ-018 SHALL transition DATA -> PARITY (macro defined) or DATA -> STOP (macro undefined); PARITY -> STOP; STOP -> IDLE.
REQ-019 SHALL assert busy in every state except IDLE.
REQ-020 SHALL pulse done high for exactly one cycle, the first IDLE cycle after STOP.
REQ-021 SHALL accept a new word in the same cycle done is high (back-to-back frames, no extra idle bit).
REQ-022 SHALL, with BIT_CYCLES=1, produce one bit per cycle with no skipped or repeated bits.
REQ-023 SHALL give frame length (2+WIDTH)*BIT_CYCLES cycles without parity, (3+WIDTH)*BIT_CYCLES with parity, measured from first START cycle to last STOP cycle inclusive.

Reset
REQ-024 SHALL, on reset high at a rising edge, go to IDLE: sout=1, busy=0, done=0, load_ready=1 next cycle; shift register, bit and cycle counters cleared.
REQ-025 SHALL abort a frame in progress when reset asserts mid-frame; no done pulse for the aborted frame.
REQ-026 SHALL give reset priority over a simultaneous load_valid.

Configuration
REQ-027 SHALL use macro SERIALIZER_PARITY_EN: defined -> PARITY state inserted after DATA, sout = XOR of the captured word (even parity); undefined -> no PARITY state, no parity logic synthesized.

Verification
REQ-028 SHALL test (WIDTH=4, BIT_CYCLES=4, no macro) load 4'h5 -> sout 0,1,0,1,0,1, each 4 cycles, done once after 24 cycles, busy high throughout.
REQ-029 SHALL test load 4'hA, then d=4'hF with load_valid held during frame -> serial data 0,1,0,1 only; 4'hF sent only after done, back-to-back.
REQ-030 SHALL test reset asserted 10 cycles into a 4'h3 frame -> next cycle sout=1, busy=0, load_ready=1; no done pulse.
REQ-031 SHALL test SERIALIZER_PARITY_EN defined: 4'h7 -> 0,1,1,1,0,1,1 (parity 1), frame 28 cycles; 4'h5 -> parity bit 0.
REQ-032 SHALL test BIT_CYCLES=1, WIDTH=8, load 8'hC3 -> sout 0,1,1,0,0,0,0,1,1,1 on consecutive cycles, done on cycle 11.
